// File: rtl/nic_pkg.sv
// Shared NIC register map, status bit helper and host-controller state encoding.
package nic_pkg;

  localparam int NIC_PACKET_WIDTH = 64;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // The NIC reports buffer full/empty in the top bit of the read word.
  function automatic int nic_status_bit(input int width);
    return width - 1;
  endfunction

  localparam int NIC_STATUS_BIT = nic_status_bit(NIC_PACKET_WIDTH);

  typedef enum logic [2:0] {
    ST_IN_STAT  = 3'd0,
    ST_IN_CHK   = 3'd1,
    ST_IN_RD    = 3'd2,
    ST_IN_CAP   = 3'd3,
    ST_OUT_SEL  = 3'd4,
    ST_OUT_STAT = 3'd5,
    ST_OUT_CHK  = 3'd6,
    ST_OUT_WR   = 3'd7
  } ctrl_state_t;

endpackage

// File: rtl/nic_host_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // NUM_REQ is a power of two, so the IDX_W-bit add wraps for free.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nic_host_ctrl.sv
// CPU-side NIC sequencer: alternates rx polling/drain with arbitrated tx writes.
//  state    | meaning
//  IN_STAT  | read in-buf status
//  IN_CHK   | in-buf full and rx register free -> read it
//  IN_RD    | read in-buf data
//  IN_CAP   | capture packet into rx register
//  OUT_SEL  | keep locked grant or lock round-robin winner
//  OUT_STAT | read out-buf status
//  OUT_CHK  | out-buf empty -> write, else retry next loop
//  OUT_WR   | write granted packet, pulse req_ready, unlock
module nic_host_ctrl
  import nic_pkg::*;
#(
  parameter int PACKET_WIDTH = NIC_PACKET_WIDTH,
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rx_valid,
  output logic [PACKET_WIDTH-1:0]         rx_data,
  input  logic                            rx_ready,
  output logic [1:0]                      addr,
  output logic [PACKET_WIDTH-1:0]         d_in,
  output logic                            nicEn,
  output logic                            nicEnWR,
  input  logic [PACKET_WIDTH-1:0]         d_out,
  output logic [REQ_IDX_W-1:0]            grant_id
);

  localparam int SB = nic_status_bit(PACKET_WIDTH);

  ctrl_state_t state_q, state_d;

  logic                    locked_q;
  logic [REQ_IDX_W-1:0]    grant_q;
  logic [NUM_REQ-1:0]      grant_oh_q;
  logic [REQ_IDX_W-1:0]    rr_ptr_q;
  logic                    rx_valid_q;
  logic [PACKET_WIDTH-1:0] rx_data_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [REQ_IDX_W-1:0]    arb_idx;
  logic                    arb_any;
  logic                    grant_live;
  logic                    wr_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_IDX_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // A requester that drops valid while locked forfeits its slot.
  assign grant_live = |(req_valid & grant_oh_q);
  assign wr_ok      = (state_q == ST_OUT_WR) && locked_q && grant_live;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IN_STAT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IN_STAT;
    case (state_q)
      ST_IN_STAT:  state_d = ST_IN_CHK;
      ST_IN_CHK:   state_d = (d_out[SB] && !rx_valid_q) ? ST_IN_RD : ST_OUT_SEL;
      ST_IN_RD:    state_d = ST_IN_CAP;
      ST_IN_CAP:   state_d = ST_OUT_SEL;
      ST_OUT_SEL: begin
        if (locked_q) state_d = grant_live ? ST_OUT_STAT : ST_IN_STAT;
        else          state_d = arb_any ? ST_OUT_STAT : ST_IN_STAT;
      end
      ST_OUT_STAT: state_d = ST_OUT_CHK;
      ST_OUT_CHK:  state_d = d_out[SB] ? ST_IN_STAT : ST_OUT_WR;
      ST_OUT_WR:   state_d = ST_IN_STAT;
      default:     state_d = ST_IN_STAT;
    endcase
  end

  always_comb begin
    addr      = NIC_IN_BUF;
    d_in      = '0;
    nicEn     = 1'b0;
    nicEnWR   = 1'b0;
    req_ready = '0;
    if (!reset) begin
      case (state_q)
        ST_IN_STAT: begin
          addr  = NIC_IN_STAT;
          nicEn = 1'b1;
        end
        ST_IN_RD: begin
          addr  = NIC_IN_BUF;
          nicEn = 1'b1;
        end
        ST_OUT_STAT: begin
          addr  = NIC_OUT_STAT;
          nicEn = 1'b1;
        end
        ST_OUT_WR: begin
          if (wr_ok) begin
            addr      = NIC_OUT_BUF;
            nicEn     = 1'b1;
            nicEnWR   = 1'b1;
            d_in      = req_data[grant_q*PACKET_WIDTH +: PACKET_WIDTH];
            req_ready = grant_oh_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q   <= 1'b0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      if (state_q == ST_OUT_SEL) begin
        if (locked_q && !grant_live) begin
          locked_q <= 1'b0;
        end else if (!locked_q && arb_any) begin
          locked_q   <= 1'b1;
          grant_q    <= arb_idx;
          grant_oh_q <= arb_gnt;
        end
      end else if (state_q == ST_OUT_WR) begin
        locked_q <= 1'b0;
        if (wr_ok) rr_ptr_q <= grant_q + REQ_IDX_W'(1);
      end

      if (state_q == ST_IN_CAP) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= d_out;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_nic_host_ctrl.sv
// Bench for nic_host_ctrl with a behavioural NIC and router drain; scoreboarded tx/rx.
module tb_nic_host_ctrl;
  import nic_pkg::*;

  localparam int PW = 64;
  localparam int NR = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*PW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           rx_valid;
  logic [PW-1:0]  rx_data;
  logic           rx_ready = 1'b0;
  logic [1:0]     addr;
  logic [PW-1:0]  d_in;
  logic           nicEn;
  logic           nicEnWR;
  logic [PW-1:0]  d_out = '0;
  logic [IW-1:0]  grant_id;

  nic_host_ctrl #(.PACKET_WIDTH(PW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .addr(addr), .d_in(d_in), .nicEn(nicEn), .nicEnWR(nicEnWR), .d_out(d_out),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [PW-1:0] data; } tx_t;
  tx_t           pend[$];
  tx_t           tx_q[$];
  logic [PW-1:0] rx_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic [PW-1:0] in_buf = '0;
  logic [PW-1:0] out_buf = '0;
  bit  in_full = 0, out_full = 0, t3 = 0;
  int  drain = 0, force_full = 0, in_rd_cnt = 0, wr_cnt = 0, full_polls = 0, out_polls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input int idx, input logic [PW-1:0] data);
    tx_t e;
    e.idx = idx;
    e.data = data;
    pend.push_back(e);
    tx_q.push_back(e);
  endtask

  task automatic inject(input logic [PW-1:0] data);
    in_buf  = data;
    in_full = 1;
    rx_q.push_back(data);
  endtask

  task automatic rst_assert();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rst_release();
    reset = 1'b0;
  endtask

  task automatic wait_tx_empty(input int budget);
    int n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("tx_drained", tx_q.size(), 0);
    repeat (10) @(posedge clk);
  endtask

  task automatic wait_rx(input int budget);
    int n = 0;
    while (!rx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_valid_seen", rx_valid, 1);
  endtask

  task automatic pulse_rx_ready();
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  // Requesters: hold valid until req_ready, then present the next queued packet.
  initial begin
    logic [NR-1:0] rdy;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        int hit;
        if (rdy[i]) req_valid[i] = 1'b0;
        hit = -1;
        if (!req_valid[i])
          for (int j = 0; j < pend.size(); j++)
            if (hit < 0 && pend[j].idx == i) hit = j;
        if (hit >= 0) begin
          req_data[i*PW +: PW] = pend[hit].data;
          req_valid[i] = 1'b1;
          pend.delete(hit);
        end
      end
    end
  end

  // NIC model: registered reads, out-buf drained by the router a few cycles after a write.
  initial begin
    logic en, wr;
    logic [1:0] a;
    logic [PW-1:0] wd;
    logic [NR-1:0] rr;
    tx_t e;
    logic [PW-1:0] re;
    forever begin
      @(negedge clk);
      en = nicEn; wr = nicEnWR; a = addr; wd = d_in; rr = req_ready;
      if (en && wr) begin
        wr_cnt++;
        check("wr_addr", a, NIC_OUT_BUF);
        check("tx_sb_nonempty", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
          e = tx_q.pop_front();
          check("wr_data", wd, e.data);
          check("ready_onehot", rr, 64'(1) << e.idx);
        end
      end else if (rr != 0) begin
        check("ready_without_write", rr, 0);
      end
      if (rx_valid && rx_ready) begin
        check("rx_sb_nonempty", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          re = rx_q.pop_front();
          check("rx_data", rx_data, re);
        end
      end
      @(posedge clk); #1;
      if (drain > 0) begin
        drain--;
        if (drain == 0) out_full = 0;
      end
      if (en && wr && a == NIC_OUT_BUF) begin
        out_buf  = wd;
        out_full = 1;
        drain    = 4;
      end else if (en && !wr) begin
        case (a)
          NIC_IN_BUF: begin
            d_out = in_buf;
            in_full = 0;
            in_rd_cnt++;
          end
          NIC_IN_STAT: d_out = {in_full, {(PW-1){1'b0}}};
          NIC_OUT_BUF: d_out = out_buf;
          default: begin
            out_polls++;
            if (force_full > 0) begin
              d_out = {1'b1, {(PW-1){1'b0}}};
              force_full--;
              full_polls++;
              if (t3) check("grant_stable", grant_id, 1);
            end else begin
              d_out = {out_full, {(PW-1){1'b0}}};
            end
          end
        endcase
      end
    end
  end

  initial begin
    int cyc, rdy_cyc, rx_cyc, wr_cyc, w0, rd0;
    bit found;

    // reset values
    @(negedge clk);
    check("rst_nicEn", nicEn, 0);
    check("rst_nicEnWR", nicEnWR, 0);
    check("rst_addr", addr, 0);
    check("rst_d_in", d_in, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_grant_id", grant_id, 0);

    // 1: single tx, latency counted from the first IN_STAT cycle (inclusive)
    rst_assert();
    push_tx(0, 64'h200200000000FA50);
    w0 = wr_cnt;
    rst_release();
    rdy_cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rdy_cyc == 0 && req_ready != 0) rdy_cyc = k;
    end
    check("t1_latency", rdy_cyc, 6);
    wait_tx_empty(100);
    check("t1_write_once", wr_cnt - w0, 1);

    // 2a: round robin with all four held
    rst_assert();
    push_tx(0, 64'h0000_0000_0000_A000);
    push_tx(1, 64'h0000_0000_0000_B001);
    push_tx(2, 64'h0000_0000_0000_C002);
    push_tx(3, 64'h0000_0000_0000_D003);
    push_tx(0, 64'h0000_0000_0000_E000);
    rst_release();
    wait_tx_empty(400);

    // 2b: after grant 2, requesters 3 and 0 -> 3 first
    rst_assert();
    push_tx(2, 64'h1111_2222_3333_0002);
    rst_release();
    wait_tx_empty(100);
    push_tx(3, 64'h1111_2222_3333_0003);
    push_tx(0, 64'h1111_2222_3333_0000);
    wait_tx_empty(200);

    // 3: out-buf reported full for three polls
    rst_assert();
    force_full = 3; full_polls = 0; out_polls = 0; t3 = 1;
    push_tx(1, 64'hDEAD_BEEF_0000_0031);
    rst_release();
    wait_tx_empty(300);
    t3 = 0;
    check("t3_full_polls", full_polls, 3);
    check("t3_write_on_first_empty", out_polls, 4);

    // 4: rx capture, hold, consume
    rst_assert();
    rx_ready = 1'b0;
    rst_release();
    inject(64'hA5A5_0000_0000_0001);
    wait_rx(50);
    check("t4_rx_data", rx_data, 64'hA5A5_0000_0000_0001);
    rd0 = in_rd_cnt;
    inject(64'h5A5A_0000_0000_0002);
    repeat (40) @(posedge clk);
    check("t4_no_reread", in_rd_cnt, rd0);
    pulse_rx_ready();
    @(negedge clk);
    check("t4_rx_cleared", rx_valid, 0);
    wait_rx(50);
    pulse_rx_ready();
    repeat (4) @(posedge clk);

    // 5: reset during OUT_CHK
    rst_assert();
    push_tx(2, 64'h0BAD_F00D_0000_0005);
    rst_release();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (nicEn && addr == NIC_OUT_STAT) found = 1;
    end
    check("t5_poll_seen", found, 1);
    w0 = wr_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_nicEn", nicEn, 0);
    check("t5_nicEnWR", nicEnWR, 0);
    check("t5_addr", addr, 0);
    check("t5_d_in", d_in, 0);
    check("t5_req_ready", req_ready, 0);
    check("t5_grant_id", grant_id, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_no_write", wr_cnt, w0);
    wait_tx_empty(100);
    check("t5_served_afresh", wr_cnt - w0, 1);

    // 6: rx and tx in the same loop
    rst_assert();
    inject(64'hCAFE_0000_0000_0006);
    push_tx(1, 64'h0000_0006_0000_0001);
    rst_release();
    rx_cyc = 0; wr_cyc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (rx_cyc == 0 && rx_valid) rx_cyc = k;
      if (wr_cyc == 0 && nicEn && nicEnWR) wr_cyc = k;
    end
    check("t6_rx_cycle", rx_cyc, 5);
    check("t6_wr_cycle", wr_cyc, 8);
    pulse_rx_ready();
    wait_tx_empty(50);

    check("end_rx_q_empty", rx_q.size(), 0);
    check("end_pend_empty", pend.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
